// File: rtl/maxpool_bin_if.sv
// Stream interface for the 2x2 max-pool / binarize block.
//   start     : level enable; low aborts the frame and returns to idle
//   state     : layer select, sampled when a frame starts
//   din       : signed conv sample, row-major
//   din_valid : din qualifier
//   dout      : signed pooled value, held between ovalid pulses
//   bin_out   : 1 when dout >= 0
//   ovalid    : one-cycle pulse per pooled value
//   done      : one-cycle pulse with the last pooled value of a frame
// master = sample source / sink (bench), slave = the pooling block.
interface maxpool_bin_if;
  logic               start;
  logic               state;
  logic signed [31:0] din;
  logic               din_valid;
  logic signed [31:0] dout;
  logic               bin_out;
  logic               ovalid;
  logic               done;

  modport master (
    output start, state, din, din_valid,
    input  dout, bin_out, ovalid, done
  );

  modport slave (
    input  start, state, din, din_valid,
    output dout, bin_out, ovalid, done
  );
endinterface

// File: rtl/maxpool_bin.sv
// 2x2 max-pool with sign binarization over a W x W conv output frame.
// Horizontal pairs are reduced as they stream in; even rows park the pair
// maximum in a line buffer, odd rows combine with it and emit one result.
//   clk : clock, posedge
//   rst : asynchronous active-high reset
//   bus : maxpool_bin_if.slave stream port (see interface header)
module maxpool_bin #(
  parameter int unsigned W0 = 24,
  parameter int unsigned W1 = 8
) (
  input logic          clk,
  input logic          rst,
  maxpool_bin_if.slave bus
);

  localparam int unsigned MaxW  = (W0 > W1) ? W0 : W1;
  localparam int unsigned CntW  = $clog2(MaxW + 1);
  localparam int unsigned IdxW  = CntW - 1;
  localparam int unsigned Depth = MaxW / 2;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e             st_q, st_d;
  logic [CntW-1:0]    w_q, w_d;
  logic [CntW-1:0]    col_q, col_d;
  logic [CntW-1:0]    row_q, row_d;
  logic signed [31:0] dout_q, dout_d;
  logic               bin_q, bin_d;
  logic               ovalid_q, ovalid_d;
  logic               done_q, done_d;
  logic signed [31:0] hold_q, hold_d;
  logic signed [31:0] lb_q [Depth];

  logic               lb_we;
  logic [IdxW-1:0]    lb_idx;
  logic signed [31:0] h, lb_rd, pooled;
  logic               col_last, row_last;

  always_comb begin
    lb_idx   = col_q[CntW-1:1];
    lb_rd    = lb_q[lb_idx];
    h        = (bus.din > hold_q) ? bus.din : hold_q;
    pooled   = (h > lb_rd) ? h : lb_rd;
    col_last = (col_q == w_q - 1'b1);
    row_last = (row_q == w_q - 1'b1);

    st_d     = st_q;
    w_d      = w_q;
    col_d    = col_q;
    row_d    = row_q;
    dout_d   = dout_q;
    bin_d    = bin_q;
    ovalid_d = 1'b0;
    done_d   = 1'b0;
    hold_d   = hold_q;
    lb_we    = 1'b0;

    unique case (st_q)
      StIdle: begin
        col_d = '0;
        row_d = '0;
        if (bus.start) begin
          st_d = StRun;
          w_d  = bus.state ? CntW'(W1) : CntW'(W0);
        end
      end
      StRun: begin
        if (bus.din_valid) begin
          if (!col_q[0]) begin
            hold_d = bus.din;
          end else if (!row_q[0]) begin
            lb_we = 1'b1;
          end else begin
            dout_d   = pooled;
            bin_d    = ~pooled[31];
            ovalid_d = 1'b1;
            if (col_last && row_last) begin
              done_d = 1'b1;
              st_d   = StFin;
            end
          end
          if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StFin: ;
      default: st_d = StIdle;
    endcase

    // Dropping start aborts from any state; no pulse may escape.
    if (!bus.start) begin
      st_d     = StIdle;
      col_d    = '0;
      row_d    = '0;
      ovalid_d = 1'b0;
      done_d   = 1'b0;
      lb_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= StIdle;
      w_q      <= CntW'(W0);
      col_q    <= '0;
      row_q    <= '0;
      dout_q   <= '0;
      bin_q    <= 1'b0;
      ovalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      w_q      <= w_d;
      col_q    <= col_d;
      row_q    <= row_d;
      dout_q   <= dout_d;
      bin_q    <= bin_d;
      ovalid_q <= ovalid_d;
      done_q   <= done_d;
    end
  end

  // Datapath storage is always written before it is read within a frame.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    if (lb_we) lb_q[lb_idx] <= h;
  end

  assign bus.dout    = dout_q;
  assign bus.bin_out = bin_q;
  assign bus.ovalid  = ovalid_q;
  assign bus.done    = done_q;

endmodule
